dcache_profiler: RTL and testbench
==================================

# dcache_profiler

Direct-mapped cache tag model that consumes the CPU's data-memory access stream (address plus read/write strobe) and classifies each access as hit or miss. It sits beside the data memory and observes every load and store the CPU issues. It reports per-access results and running hit/miss totals, which gives a synthesizable, cycle-accurate counterpart to offline cache-trace analysis. It holds tags and valid bits only, no data.

## Interface
- `OFFSET_W`, default 4: byte-offset bits per block (16-byte lines).
- `INDEX_W`, default 3: index bits; LINES = 2^INDEX_W = 8.
- `TAG_W`, default 32-OFFSET_W-INDEX_W = 25: stored tag width.
- `clk_i`, input, 1: clock. One clock domain; all state updates on the rising edge.
- `rst_i`, input, 1: reset, synchronous and active-high.
- `req_valid_i`, input, 1: an access is presented (MemRead or MemWrite asserted).
- `req_ready_o`, output, 1: block can accept an access this cycle.
- `req_addr_i`, input, 32: byte address of the access.
- `req_write_i`, input, 1: 1 = store, 0 = load.
- `flush_i`, input, 1: single-cycle pulse that invalidates all lines.
- `rsp_valid_o`, output, 1: result of the access accepted on the previous edge.
- `rsp_hit_o`, output, 1: 1 = hit, 0 = miss; meaningful only when `rsp_valid_o` is 1.
- `rsp_write_o`, output, 1: echo of `req_write_i` for the reported access.
- `rsp_addr_o`, output, 32: echo of `req_addr_i` for the reported access.
- `hit_count_o`, output, 32: total hits since reset.
- `miss_count_o`, output, 32: total misses since reset.

## Operation
- Address split: tag = addr[31:OFFSET_W+INDEX_W], index = addr[OFFSET_W+INDEX_W-1:OFFSET_W]. Offset bits are ignored.
- FSM states:
  - FLUSH: counter `fidx` walks 0..LINES-1, clearing `valid[fidx]` each cycle. When `fidx` = LINES-1, go to READY.
  - READY: accepts requests.
- `req_ready_o` = (state == READY). It is a registered-state decode only, with no combinational path from any input.
- Accept: an access is accepted on an edge where `req_valid_i` && `req_ready_o`.
- Hit condition: `valid[index]` && `tag_mem[index]` == tag. The lookup uses array contents as of before the edge.
- On a miss, at the same edge:
  - `tag_mem[index]` <= tag.
  - `valid[index]` <= 1.
  - Allocation applies to both loads and stores (write-allocate).
- On a hit, the tag array is unchanged.
- Counters: on accept, `hit_count_o` or `miss_count_o` increments by 1. Both saturate at 32'hFFFF_FFFF; no wrap.
- Counters are cleared only by `rst_i`. A flush does not touch them.
- Flush request: `flush_i` sampled high in READY moves the FSM to FLUSH next cycle with `fidx` = 0.
  - If a request is accepted on that same edge, it is fully processed (classified, counted, allocated) first.
  - The flush then invalidates that allocation along with every other line.
- `flush_i` sampled in FLUSH is ignored; the walk is not restarted.
- Reset, including mid-flush or mid-stream:
  - state <= FLUSH, `fidx` <= 0.
  - `valid` is cleared by the walk; tag contents are don't-care.
  - Counters <= 0, `rsp_valid_o` <= 0.
  - Any in-flight response is dropped.

## Timing
- Reset values:
  - `req_ready_o` = 0.
  - `rsp_valid_o` = 0; `rsp_hit_o`, `rsp_write_o` = 0; `rsp_addr_o` = 0.
  - `hit_count_o` = `miss_count_o` = 0.
- After `rst_i` is deasserted, `req_ready_o` stays 0 for exactly LINES (8) cycles, then rises.
- Latency: for an access accepted at edge N:
  - `rsp_valid_o`, `rsp_hit_o`, `rsp_write_o` and `rsp_addr_o` are valid in cycle N..N+1.
  - The counter is updated in the same cycle.
- `rsp_valid_o` is a one-cycle pulse per accepted access.
- Throughput: one access per cycle in READY.
- Back-to-back accesses to the same index see the tag written at the previous edge, so a miss followed by an access to the same block reports a hit.
- A flush blocks input for LINES cycles. `req_ready_o` is low from the cycle after `flush_i` is sampled through the cycle `fidx` = LINES-1.
- The producer must hold `req_valid_i`/`req_addr_i` until accepted. The block never drops a presented access while `req_ready_o` = 0; it simply does not accept it.

## Test plan
- Reset release: `rst_i` high 2 cycles, then low. Required: `req_ready_o` = 0 for 8 cycles then 1; both counts 0; `rsp_valid_o` never high.
- Read 0x0000_0000, then write 0x0000_0004, back-to-back. Required: miss then hit, `rsp_write_o` = 0 then 1, `hit_count_o` = 1, `miss_count_o` = 1.
- Conflict sequence 0x00, 0x80, 0x00, all index 0 with different tags. Required: miss, miss, miss; `miss_count_o` = 3, `hit_count_o` = 0.
- Access 0x10 (miss); `flush_i` pulse; `req_ready_o` low 8 cycles; access 0x10 again. Required: miss, `miss_count_o` = 2. `flush_i` pulsed again during the walk does not extend it.
- Stream 0x00..0x7C step 4 with `req_valid_i` held for 32 cycles. Required: misses at each 16-byte boundary; final `miss_count_o` = 8, `hit_count_o` = 24; `rsp_valid_o` high 32 consecutive cycles.
- Assert `rst_i` during the 4th cycle of a flush walk after 5 counted accesses. Required: counts return to 0; a full 8-cycle walk restarts; subsequent access 0x10 reports miss.

Source files
------------

// File: rtl/dcache_profiler_if.sv
// Access-stream and result bundle between a CPU data-memory port and the cache profiler.
interface dcache_profiler_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_write_i;
  logic        flush_i;
  logic        rsp_valid_o;
  logic        rsp_hit_o;
  logic        rsp_write_o;
  logic [31:0] rsp_addr_o;
  logic [31:0] hit_count_o;
  logic [31:0] miss_count_o;

  modport master (
    output req_valid_i, req_addr_i, req_write_i, flush_i,
    input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_write_o, rsp_addr_o,
           hit_count_o, miss_count_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_write_i, flush_i,
    output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_write_o, rsp_addr_o,
           hit_count_o, miss_count_o
  );
endinterface

// File: rtl/dcache_profiler.sv
// Direct-mapped tag-only cache model that classifies each observed data access as hit or miss
// and keeps saturating hit/miss totals.
module dcache_profiler #(
  parameter int OFFSET_W = 4,
  parameter int INDEX_W  = 3,
  parameter int TAG_W    = 32 - OFFSET_W - INDEX_W
) (
  input logic              clk_i,
  input logic              rst_i,
  dcache_profiler_if.slave bus
);

  localparam int LINES = 1 << INDEX_W;

  typedef enum logic {FLUSH, READY} state_t;

  state_t             state;
  state_t             nextState;
  logic [INDEX_W-1:0] fidx;
  logic [TAG_W-1:0]   tagMem [LINES];
  logic [LINES-1:0]   validBits;

  logic [TAG_W-1:0]   reqTag;
  logic [INDEX_W-1:0] reqIndex;
  logic               accept;
  logic               lookupHit;

  assign reqTag    = bus.req_addr_i[31 -: TAG_W];
  assign reqIndex  = bus.req_addr_i[OFFSET_W +: INDEX_W];
  assign accept    = bus.req_valid_i && bus.req_ready_o;
  assign lookupHit = validBits[reqIndex] && (tagMem[reqIndex] == reqTag);

  // fidx rests at zero in READY so every walk starts from line 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= FLUSH;
      fidx  <= '0;
    end else begin
      state <= nextState;
      fidx  <= (state == FLUSH) ? fidx + INDEX_W'(1) : '0;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      FLUSH: if (fidx == INDEX_W'(LINES - 1)) nextState = READY;
      READY: if (bus.flush_i) nextState = FLUSH;
      default: nextState = FLUSH;
    endcase
  end

  always_comb begin
    bus.req_ready_o = (state == READY);
  end

  // A request accepted on the same edge as a flush allocates here; the walk then clears it.
  always_ff @(posedge clk_i) begin
    if (state == FLUSH) begin
      validBits[fidx] <= 1'b0;
    end else if (accept && !lookupHit) begin
      validBits[reqIndex] <= 1'b1;
      tagMem[reqIndex]    <= reqTag;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.rsp_valid_o  <= 1'b0;
      bus.rsp_hit_o    <= 1'b0;
      bus.rsp_write_o  <= 1'b0;
      bus.rsp_addr_o   <= '0;
      bus.hit_count_o  <= '0;
      bus.miss_count_o <= '0;
    end else begin
      bus.rsp_valid_o <= accept;
      if (accept) begin
        bus.rsp_hit_o   <= lookupHit;
        bus.rsp_write_o <= bus.req_write_i;
        bus.rsp_addr_o  <= bus.req_addr_i;
        if (lookupHit) begin
          if (bus.hit_count_o != 32'hFFFF_FFFF) bus.hit_count_o <= bus.hit_count_o + 32'd1;
        end else begin
          if (bus.miss_count_o != 32'hFFFF_FFFF) bus.miss_count_o <= bus.miss_count_o + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dcache_profiler.sv
// Directed and randomized checks of dcache_profiler against an array-based cache model.
module tb_dcache_profiler;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bit          refValid [8];
  int unsigned refTag   [8];
  int unsigned expHits;
  int unsigned expMisses;

  dcache_profiler_if bus ();

  dcache_profiler dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic bit modelAccess(input logic [31:0] addr);
    int unsigned line = (addr / 16) % 8;
    int unsigned tag  = addr / 128;
    bit hit = refValid[line] && (refTag[line] == tag);
    if (hit) expHits++;
    else begin
      expMisses++;
      refValid[line] = 1'b1;
      refTag[line]   = tag;
    end
    return hit;
  endfunction

  function automatic void modelInvalidate();
    for (int i = 0; i < 8; i++) refValid[i] = 1'b0;
  endfunction

  task automatic checkOutput(input bit expHit, input bit expWrite, input logic [31:0] expAddr);
    checkVal("rspValid", bus.rsp_valid_o, 1);
    checkVal("rspHit", bus.rsp_hit_o, expHit);
    checkVal("rspWrite", bus.rsp_write_o, expWrite);
    checkVal("rspAddr", bus.rsp_addr_o, expAddr);
    checkVal("hitCount", bus.hit_count_o, expHits);
    checkVal("missCount", bus.miss_count_o, expMisses);
  endtask

  // Called at a falling edge; returns at the falling edge after the access is accepted.
  task automatic applyStimulus(input logic [31:0] addr, input bit write, input int planHit);
    bit expHit;
    checkVal("readyBeforeAccess", bus.req_ready_o, 1);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = addr;
    bus.req_write_i = write;
    expHit = modelAccess(addr);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    checkOutput(expHit, write, addr);
    if (planHit >= 0) checkVal("planHit", bus.rsp_hit_o, planHit[0]);
  endtask

  task automatic waitReady(input int expected, input int pulseAt);
    int lowCycles = 0;
    while (bus.req_ready_o !== 1'b1 && lowCycles < 20) begin
      checkVal("rspIdleInWalk", bus.rsp_valid_o, 0);
      if (lowCycles == pulseAt) bus.flush_i = 1'b1;
      lowCycles++;
      @(posedge clk);
      @(negedge clk);
      bus.flush_i = 1'b0;
    end
    checkVal("readyLowCycles", lowCycles, expected);
  endtask

  task automatic doFlush(input int pulseAt);
    bus.flush_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush_i = 1'b0;
    modelInvalidate();
    waitReady(8, pulseAt);
  endtask

  task automatic doReset();
    bus.req_valid_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelInvalidate();
    expHits   = 0;
    expMisses = 0;
    checkVal("rstHitCount", bus.hit_count_o, 0);
    checkVal("rstMissCount", bus.miss_count_o, 0);
    checkVal("rstRspValid", bus.rsp_valid_o, 0);
    checkVal("rstRspAddr", bus.rsp_addr_o, 0);
    checkVal("rstReady", bus.req_ready_o, 0);
    waitReady(8, -1);
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst             = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_write_i = 1'b0;
    bus.flush_i     = 1'b0;
    @(negedge clk);

    doReset();
    applyStimulus(32'h0000_0000, 1'b0, 0);
    applyStimulus(32'h0000_0004, 1'b1, 1);
    checkVal("t1Hits", bus.hit_count_o, 1);
    checkVal("t1Misses", bus.miss_count_o, 1);

    doReset();
    applyStimulus(32'h0000_0000, 1'b0, 0);
    applyStimulus(32'h0000_0080, 1'b0, 0);
    applyStimulus(32'h0000_0000, 1'b1, 0);
    checkVal("t2Hits", bus.hit_count_o, 0);
    checkVal("t2Misses", bus.miss_count_o, 3);

    doReset();
    applyStimulus(32'h0000_0010, 1'b0, 0);
    doFlush(3);
    applyStimulus(32'h0000_0010, 1'b0, 0);
    checkVal("t3Misses", bus.miss_count_o, 2);

    doReset();
    for (int a = 0; a < 32'h80; a += 4) applyStimulus(a, a[2], -1);
    checkVal("t4Hits", bus.hit_count_o, 24);
    checkVal("t4Misses", bus.miss_count_o, 8);

    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(32'h0000_0100 + 32'(i * 16), 1'b0, -1);
    bus.flush_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush_i = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelInvalidate();
    expHits   = 0;
    expMisses = 0;
    checkVal("midRstHits", bus.hit_count_o, 0);
    checkVal("midRstMisses", bus.miss_count_o, 0);
    waitReady(8, -1);
    applyStimulus(32'h0000_0010, 1'b0, 0);

    for (int n = 0; n < 200; n++) begin
      int unsigned r = $urandom_range(0, 19);
      if (r == 0) doFlush(-1);
      else if (r < 4) begin
        @(posedge clk);
        @(negedge clk);
        checkVal("rspIdle", bus.rsp_valid_o, 0);
      end else begin
        logic [31:0] addr = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4)
                            | $urandom_range(0, 15);
        applyStimulus(addr, 1'($urandom_range(0, 1)), -1);
      end
    end
    checkVal("finalHits", bus.hit_count_o, expHits);
    checkVal("finalMisses", bus.miss_count_o, expMisses);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
